// File: rtl/uart_word_rx_if.sv
// Word-level handshake between uart_word_rx (master) and its consumer (slave).
interface uart_word_rx_if #(parameter int RSIZE = 8);
  logic               enable;
  logic               ready;
  logic [8*RSIZE-1:0] rdata;
  logic               frame_err;
  logic               overflow;

  modport master (input enable, output ready, rdata, frame_err, overflow);
  modport slave  (output enable, input ready, rdata, frame_err, overflow);
endinterface

// File: rtl/uart_word_rx.sv
// 8N1 UART receiver packing RSIZE bytes (first byte in the MSBs) into one word.
// Optional inter-byte idle timeout: define UART_WORD_RX_TIMEOUT_EN.
module uart_word_rx #(
  parameter int DIVIDER      = 217,
  parameter int RSIZE        = 8,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ftdi_to_fpga,
  uart_word_rx_if.master  bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int W  = 8 * RSIZE;
  localparam int CW = $clog2(DIVIDER);
  localparam int BW = (RSIZE > 1) ? $clog2(RSIZE) : 1;

  if (DIVIDER < 4 || RSIZE < 1 || TIMEOUT_BITS < 1) begin : g_cfg_chk
    $error("uart_word_rx: DIVIDER must be >= 4, RSIZE and TIMEOUT_BITS >= 1");
  end

  logic          sync1_q, sync2_q, prev_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [W-1:0]  asm_q, asm_d, rdata_q, rdata_d;
  logic          ready_q, ready_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic          line, fall, half_tick, bit_tick, byte_ok, word_done;

  assign line      = sync2_q;
  assign fall      = prev_q & ~sync2_q;
  assign half_tick = (cnt_q == CW'(DIVIDER / 2 - 1));
  assign bit_tick  = (cnt_q == CW'(DIVIDER - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    ferr_d  = ferr_q;
    byte_ok = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) state_d = S_START;
      end
      S_START: if (half_tick) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = line ? S_IDLE : S_DATA;
      end
      S_DATA: if (bit_tick) begin
        cnt_d = '0;
        sh_d  = {line, sh_q[7:1]};
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: if (bit_tick) begin
        cnt_d   = '0;
        state_d = S_IDLE;
        if (line) byte_ok = 1'b1;
        else      ferr_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef UART_WORD_RX_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_BITS * DIVIDER;
  localparam int TW       = $clog2(TO_LIMIT);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_armed, to_fire;

  // Only idle time with a partial word pending counts toward the timeout.
  assign to_armed = (state_q == S_IDLE) && (bcnt_q != '0);
  assign to_fire  = to_armed && (to_cnt_q == TW'(TO_LIMIT - 1));

  always_comb begin
    to_cnt_d = '0;
    if (to_armed && !to_fire) to_cnt_d = to_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  logic to_fire;
  assign to_fire = 1'b0;
`endif

  always_comb begin
    bcnt_d    = bcnt_q;
    asm_d     = asm_q;
    word_done = 1'b0;
    if (byte_ok) begin
      asm_d = (asm_q << 8) | W'(sh_q);
      if (bcnt_q == BW'(RSIZE - 1)) begin
        bcnt_d    = '0;
        word_done = 1'b1;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end else if (to_fire) begin
      bcnt_d = '0;
      asm_d  = '0;
    end
  end

  // A word may load into a full holding register only if it is being drained now.
  always_comb begin
    ready_d = ready_q;
    rdata_d = rdata_q;
    ovf_d   = ovf_q;
    if (ready_q && bus.enable) ready_d = 1'b0;
    if (word_done) begin
      if (!ready_q || bus.enable) begin
        rdata_d = asm_d;
        ready_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      bcnt_q  <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= ftdi_to_fpga;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.rdata     = rdata_q;
  assign bus.frame_err = ferr_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_uart_word_rx.sv
// Directed + randomized bench for uart_word_rx against a byte-queue reference model.
module tb_uart_word_rx;
  localparam int D  = 4;
  localparam int RS = 2;
  localparam int TB = 2;

  logic clk = 1'b0;
  logic reset;
  logic line;
  always #5 clk = ~clk;

  uart_word_rx_if #(.RSIZE(RS)) bus();
  uart_word_rx #(.DIVIDER(D), .RSIZE(RS), .TIMEOUT_BITS(TB)) dut (
    .clk(clk), .reset(reset), .ftdi_to_fpga(line), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  byte unsigned  part_q[$];
  logic          m_ready, m_fe, m_ov;
  logic [8*RS-1:0] m_rdata;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void model_reset();
    part_q.delete();
    m_ready = 1'b0;
    m_rdata = '0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
  endfunction

  function automatic void model_frame(logic [7:0] b, bit ok);
    logic [8*RS-1:0] w;
    if (!ok) begin
      m_fe = 1'b1;
      return;
    end
    part_q.push_back(b);
    if (part_q.size() == RS) begin
      w = '0;
      foreach (part_q[i]) w = (w << 8) | (8*RS)'(part_q[i]);
      part_q.delete();
      if (m_ready) m_ov = 1'b1;
      else begin
        m_rdata = w;
        m_ready = 1'b1;
      end
    end
  endfunction

  task automatic send(logic [7:0] b, bit stop_ok, int gap);
    line = 1'b0; tick(D);
    for (int i = 0; i < 8; i++) begin
      line = b[i]; tick(D);
    end
    line = stop_ok; tick(D);
    line = 1'b1; tick(gap);
    model_frame(b, stop_ok);
  endtask

  task automatic consume();
    bus.enable = 1'b1; tick(1);
    bus.enable = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".ready"}, bus.ready, m_ready);
    chk({tag, ".rdata"}, bus.rdata, m_rdata);
    chk({tag, ".ferr"},  bus.frame_err, m_fe);
    chk({tag, ".ovf"},   bus.overflow, m_ov);
  endtask

  task automatic do_reset();
    reset = 1'b1; line = 1'b1; bus.enable = 1'b0;
    tick(2);
    reset = 1'b0;
    model_reset();
    check_all("reset");
  endtask

  initial begin
    logic [7:0] b2;
    model_reset();
    do_reset();

    // basic word, held until consumed
    send(8'hA5, 1'b1, 2); send(8'h3C, 1'b1, 2);
    check_all("word");
    chk("word.lit", bus.rdata, 16'hA53C);
    tick(10);
    check_all("hold");
    consume();
    check_all("xfer");
    chk("xfer.lit", bus.ready, 1'b0);

    // bad stop bit drops the byte and sets frame_err
    send(8'h11, 1'b0, 2); send(8'h22, 1'b1, 2); send(8'h33, 1'b1, 2);
    check_all("ferr");
    chk("ferr.lit", {bus.frame_err, bus.rdata}, {1'b1, 16'h2233});
    consume();

    // second word while first unconsumed
    send(8'h01, 1'b1, 2); send(8'h02, 1'b1, 2);
    send(8'h03, 1'b1, 2); send(8'h04, 1'b1, 2);
    check_all("ovf");
    chk("ovf.lit", {bus.overflow, bus.rdata}, {1'b1, 16'h0102});
    consume();
    check_all("ovf.xfer");

    // reset mid-frame of byte 2 with state to clear
    send(8'h55, 1'b1, 2); send(8'h66, 1'b1, 2);
    send(8'h12, 1'b1, 2);
    b2 = 8'h34;
    line = 1'b0; tick(D);
    for (int i = 0; i < 5; i++) begin
      line = b2[i]; tick(D);
    end
    reset = 1'b1; line = 1'b1;
    tick(1);
    chk("rst.mid", {bus.ready, bus.rdata, bus.frame_err, bus.overflow}, '0);
    reset = 1'b0;
    model_reset();
    tick(2);
    send(8'hBE, 1'b1, 2); send(8'hEF, 1'b1, 2);
    check_all("beef");
    chk("beef.lit", bus.rdata, 16'hBEEF);
    consume();

    // one-cycle glitch must not produce a byte
    line = 1'b0; tick(1); line = 1'b1; tick(12);
    check_all("glitch");
    send(8'h5A, 1'b1, 2); send(8'hC3, 1'b1, 2);
    check_all("glitch.word");
    chk("glitch.lit", bus.rdata, 16'h5AC3);
    consume();

    // inter-byte idle timeout
    send(8'h77, 1'b1, 9);
`ifdef UART_WORD_RX_TIMEOUT_EN
    part_q.delete();
`endif
    send(8'h88, 1'b1, 2); send(8'h99, 1'b1, 2);
    check_all("tmo");
`ifdef UART_WORD_RX_TIMEOUT_EN
    chk("tmo.lit", bus.rdata, 16'h8899);
`else
    chk("tmo.lit", bus.rdata, 16'h7788);
`endif

    // random frames, stop errors and consume pulses
    do_reset();
    for (int n = 0; n < 40; n++) begin
      send(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), 2);
      if ($urandom_range(0, 2) == 0) consume();
      check_all("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_word_rx.md
UART_WORD_RX -- requirements
Module: uart_word_rx

Interface
REQ-001 Parameter DIVIDER, default 217 (25000000/115200), clk cycles per serial bit period; SHALL be >= 4.
REQ-002 Parameter RSIZE, default 8, bytes per assembled word; SHALL be >= 1.
REQ-003 Parameter TIMEOUT_BITS, default 32, inter-byte idle limit in bit periods; used only when the configuration feature is compiled in.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ftdi_to_fpga  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 enable  input  1  consumer accepts the presented word.
REQ-008 ready  output  1  rdata holds a valid word.
REQ-009 rdata  output  8*RSIZE  assembled word; first received byte in bits [8*RSIZE-1:8*RSIZE-8].
REQ-010 frame_err  output  1  sticky; a stop bit sampled low.
REQ-011 overflow  output  1  sticky; a completed word was dropped.

Function
REQ-012 ftdi_to_fpga SHALL pass a 2-flop synchronizer; only its output is sampled.
REQ-013 Bit FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE -> START on a synchronized high-to-low transition.
REQ-015 START SHALL wait DIVIDER/2 cycles, then go to DATA if the line is low; otherwise return to IDLE with no byte and no flag.
REQ-016 DATA SHALL sample 8 bits at DIVIDER-cycle intervals from mid-start, shifting LSB first, then go to STOP.
REQ-017 STOP SHALL sample after a further DIVIDER cycles: high -> byte accepted; low -> byte discarded, frame_err set, byte count unchanged. Either way the FSM returns to IDLE.
REQ-018 Accepted bytes SHALL shift into an assembly register MSB-byte first; a byte counter 0..RSIZE-1 wraps to 0 when byte RSIZE is accepted.
REQ-019 On word completion with the holding register empty (or being consumed in the same cycle), the word SHALL load into rdata and ready SHALL be 1 the next cycle.
REQ-020 Handshake: a transfer occurs in a cycle with ready=1 and enable=1; ready SHALL drop the following cycle unless a new word loads in that same cycle, in which case ready stays 1 with the new rdata.
REQ-021 While ready=1 and enable=0, rdata SHALL hold stable; reception continues into the assembly register.
REQ-022 A word completing while ready=1 and enable=0 SHALL be dropped and overflow set; rdata is unchanged.
REQ-023 enable while ready=0 SHALL have no effect.
REQ-024 First-byte-to-ready latency SHALL equal the serial time of RSIZE frames plus at most 3 clk cycles.

Reset
REQ-025 reset SHALL have priority over all other events, including mid-frame or mid-word.
REQ-026 Reset values: FSM IDLE, counters 0, assembly register 0, rdata 0, ready 0, frame_err 0, overflow 0, synchronizer flops 1.
REQ-027 The first cycle after reset deasserts SHALL NOT detect a start bit unless the synchronized line is seen to fall.

Configuration
REQ-028 Macro UART_WORD_RX_TIMEOUT_EN: when defined, with byte count nonzero and the FSM in IDLE for TIMEOUT_BITS*DIVIDER consecutive cycles, the partial word SHALL be discarded and the byte count cleared; ready, rdata and the flags are unaffected.
REQ-029 Without UART_WORD_RX_TIMEOUT_EN, a partial word SHALL be retained indefinitely and no timeout counter exists.

Verification (DIVIDER=4, RSIZE=2 unless noted)
REQ-030 Send 0xA5 then 0x3C with enable=0 -> ready=1, rdata=0xA53C, stable until enable pulses; ready=0 the cycle after the transfer.
REQ-031 Send 0x11 with stop bit low, then 0x22, 0x33 -> frame_err=1, rdata=0x2233.
REQ-032 Hold enable=0; send 0x0102 then 0x0304 -> rdata=0x0102, overflow=1; after enable, ready=0.
REQ-033 Glitch low for 1 cycle on an idle line -> no byte, no flag, FSM back in IDLE.
REQ-034 Assert reset after the 5th data bit of byte 2 -> all outputs 0 next cycle; then 0xBEEF is received cleanly.
REQ-035 With UART_WORD_RX_TIMEOUT_EN, TIMEOUT_BITS=2: send 0x77, idle 9 cycles, send 0x88, 0x99 -> rdata=0x8899; without the macro -> rdata=0x7788.
